decrypting_entity: RTL
======================

# decrypting_entity

ElGamal decryption stage sitting directly downstream of `encrypting_entity`. It accepts the public-key component `a = g^k mod p` and the cryptogram `b = m·y^k mod p`, and recovers `m = b·a^(p-1-x) mod p` using the private key `x`. It is built on a single time-shared bit-serial modular multiplier. Its input handshake mates directly with `encrypting_entity`'s `output_a`/`output_b` AXI-Stream-style ports.

## Interface
- `SIZE`, 64: operand width in bits for p, x, a, b, m.
- `clk`  in  1  clock; all logic rising-edge.
- `rst`  in  1  asynchronous, active-high reset.
- `input_p_tdata`  in  SIZE  odd prime modulus.
- `input_p_tvalid`  in  1  p valid.
- `input_x_key_tdata`  in  SIZE  private key, 1 ≤ x ≤ p-2.
- `input_x_key_tvalid`  in  1  x valid.
- `input_a_tdata` / `input_a_tvalid` / `input_a_tready`  in/in/out  SIZE/1/1  public-key component, a < p.
- `input_b_tdata` / `input_b_tvalid` / `input_b_tready`  in/in/out  SIZE/1/1  cryptogram, b < p.
- `output_m_tdata` / `output_m_tvalid` / `output_m_tready`  out/out/in  SIZE/1/1  recovered plaintext.

## Operation
- States: IDLE → EXP → FINAL → OUT → IDLE.
- IDLE:
  - `input_a_tready` and `input_b_tready` are driven identically, high only when all four input tvalids are high.
  - The accept cycle latches p, x, a, b and computes e = p-1-x in SIZE bits.
  - Acc is set to 1 and base to a.
- EXP: walk e LSB-first over all SIZE bits. Each bit does a multiply step followed by a square step.
  - Multiply step (bit = 1): acc ← acc·base mod p.
  - Square step: base ← base·base mod p.
  - Bits with value 0 skip the multiply step.
- FINAL: acc ← acc·b mod p.
- OUT:
  - `output_m_tvalid` is high and `output_m_tdata` = acc.
  - Both are held stable until `output_m_tready` is high, then the block returns to IDLE.
- Multiplier:
  - Interleaved MSB-first: r ← 2r + bitᵢ(x)·y, then conditional subtract of p, at most twice, in the same cycle.
  - Internal r is SIZE+2 bits wide; the result is always < p.
- Boundaries:
  - a = 0 gives m = 0.
  - b = 0 gives m = 0.
  - Out-of-range p, x, a or b produce undefined data, but the FSM still completes.
- Changes on p/x/a/b after acceptance are ignored.
- No input is accepted outside IDLE; all tready outputs are low.
- Reset, at any time including mid-operation: return to IDLE. All outputs become 0, all registers clear, and any in-flight result is discarded.

## Timing
- Each modmul op takes exactly SIZE+1 cycles from issue to registered result.
- Let N = number of modmul ops:
  - Default: N = SIZE + popcount(e) + 1.
  - Constant-time mode: N = 2·SIZE + 1.
- `output_m_tvalid` rises N·(SIZE+1)+2 cycles after the accept edge.
- Back-to-back operation: the earliest next accept is the cycle after the OUT handshake.
- Reset values: all tready = 0, `output_m_tvalid` = 0, `output_m_tdata` = 0.

## Configuration
- `DECRYPT_CONST_TIME_EN`:
  - Defined: the multiply step runs for every exponent bit, and its result is discarded when the bit is 0. Latency then depends only on SIZE, which closes the timing side channel.
  - Undefined: zero bits skip the multiply step, giving a data-dependent latency.

## Structure
- Package `elgamal_pkg`:
  - FSM state enum, including the EXP multiply/square sub-phase.
  - Default SIZE.
  - Localparam MODMUL_CYCLES = SIZE+1.
- Sub-module `mod_mult`:
  - Parameter SIZE.
  - Ports: clk, rst, start, x, y, p, result, done.
  - Issue and `done` are one-cycle pulses.

## Test plan
- SIZE=8, p=23, x=6, a=10, b=19:
  - m = 7 in both modes.
  - Default mode: tvalid rises after 92 cycles (e = 16, popcount 1).
  - Constant-time mode: tvalid rises after 155 cycles.
- SIZE=8, p=23, x=6, a=0, b=19 → m = 0; b=0 with a=10 → m = 0.
- Backpressure: `output_m_tready` held low for 20 cycles after tvalid rises → m=7 held stable, no new accept, a/b tready stay low.
- Reset mid-operation: `rst` pulsed 30 cycles into EXP → all outputs 0 the same cycle. A new transaction then returns m = 7 with nominal latency.
- Partial inputs: only a_tvalid high → no tready, no accept. Once b_tvalid rises → accept in that cycle.
- SIZE=64 loopback from `encrypting_entity`: p=18446744073709551337, matching private key → m = 98154719832413245 recovered.

Source files
------------

// File: rtl/elgamal_pkg.sv
// Shared types and constants for the ElGamal decryption datapath.
// Optional feature macro: DECRYPT_CONST_TIME_EN (consumed by decrypting_entity).
package elgamal_pkg;

    localparam int unsigned DEFAULT_SIZE  = 64;
    localparam int unsigned MODMUL_CYCLES = DEFAULT_SIZE + 1;

    // Top-level sequencer states; EXP is split into its multiply and square sub-phases.
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXP_MUL,
        ST_EXP_SQR,
        ST_FINAL,
        ST_OUT
    } dec_state_e;

    // Cycles from issuing a modular multiply to its result being registered by the sequencer.
    function automatic int unsigned modmul_cycles(input int unsigned size);
        return size + 1;
    endfunction

endpackage

// File: rtl/decrypting_entity_if.sv
// Stream handshake bundle for decrypting_entity: key/modulus, (a, b) in, m out.
interface decrypting_entity_if
    import elgamal_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
);

    logic [SIZE-1:0] input_p_tdata;
    logic            input_p_tvalid;
    logic [SIZE-1:0] input_x_key_tdata;
    logic            input_x_key_tvalid;
    logic [SIZE-1:0] input_a_tdata;
    logic            input_a_tvalid;
    logic            input_a_tready;
    logic [SIZE-1:0] input_b_tdata;
    logic            input_b_tvalid;
    logic            input_b_tready;
    logic [SIZE-1:0] output_m_tdata;
    logic            output_m_tvalid;
    logic            output_m_tready;

    // Decryptor side.
    modport slave (
        input  input_p_tdata, input_p_tvalid,
        input  input_x_key_tdata, input_x_key_tvalid,
        input  input_a_tdata, input_a_tvalid,
        output input_a_tready,
        input  input_b_tdata, input_b_tvalid,
        output input_b_tready,
        output output_m_tdata, output_m_tvalid,
        input  output_m_tready
    );

    // Upstream producer / downstream consumer side.
    modport master (
        output input_p_tdata, input_p_tvalid,
        output input_x_key_tdata, input_x_key_tvalid,
        output input_a_tdata, input_a_tvalid,
        input  input_a_tready,
        output input_b_tdata, input_b_tvalid,
        input  input_b_tready,
        input  output_m_tdata, output_m_tvalid,
        output output_m_tready
    );

endinterface

// File: rtl/decrypting_entity_mod_mult.sv
// Bit-serial interleaved modular multiplier: result = x*y mod p, MSB-first, one bit per cycle.
// Operands are captured on the start pulse; done pulses for one cycle with result valid.
module mod_mult
    import elgamal_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [SIZE-1:0] x,
    input  logic [SIZE-1:0] y,
    input  logic [SIZE-1:0] p,
    output logic [SIZE-1:0] result,
    output logic            done
);

    localparam int unsigned RW    = SIZE + 2;
    localparam int unsigned ITERS = modmul_cycles(SIZE) - 1;
    localparam int unsigned CNT_W = $clog2(SIZE + 1);

    logic [SIZE-1:0]  r_q;
    logic [SIZE-1:0]  xs_q;
    logic [SIZE-1:0]  y_q;
    logic [SIZE-1:0]  p_q;
    logic [CNT_W-1:0] cnt_q;
    logic             busy_q;
    logic             done_q;

    // One interleaved step: 2r + bit*y, then up to two subtractions of p (2r+y < 3p).
    function automatic logic [SIZE-1:0] mm_step(input logic [SIZE-1:0] r_v,
                                                 input logic            bit_v,
                                                 input logic [SIZE-1:0] y_v,
                                                 input logic [SIZE-1:0] p_v);
        logic [RW-1:0] t;
        logic [RW-1:0] pw;
        pw = RW'(p_v);
        t  = (RW'(r_v) << 1) + (bit_v ? RW'(y_v) : RW'(0));
        if (t >= pw) t = t - pw;
        if (t >= pw) t = t - pw;
        return SIZE'(t);
    endfunction

    // Iteration engine: first bit on the start cycle, remaining bits while busy.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q    <= '0;
            xs_q   <= '0;
            y_q    <= '0;
            p_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                r_q    <= mm_step('0, x[SIZE-1], y, p);
                xs_q   <= x << 1;
                y_q    <= y;
                p_q    <= p;
                cnt_q  <= CNT_W'(ITERS - 1);
                busy_q <= (ITERS > 1);
                done_q <= (ITERS == 1);
            end else if (busy_q) begin
                r_q   <= mm_step(r_q, xs_q[SIZE-1], y_q, p_q);
                xs_q  <= xs_q << 1;
                cnt_q <= cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign result = r_q;
    assign done   = done_q;

endmodule

// File: rtl/decrypting_entity.sv
// ElGamal decryption: m = b * a^(p-1-x) mod p over one time-shared mod_mult.
// Optional feature macro: DECRYPT_CONST_TIME_EN -- run the multiply step for every
// exponent bit (result dropped on zero bits) so latency depends only on SIZE.
module decrypting_entity
    import elgamal_pkg::*;
#(
    parameter int unsigned SIZE = DEFAULT_SIZE
) (
    input  logic              clk,
    input  logic              rst,
    decrypting_entity_if.slave bus
);

    localparam int unsigned CNT_W = $clog2(SIZE + 1);

`ifdef DECRYPT_CONST_TIME_EN
    localparam bit CONST_TIME = 1'b1;
`else
    localparam bit CONST_TIME = 1'b0;
`endif

    dec_state_e       state_q;
    logic [SIZE-1:0]  p_q;
    logic [SIZE-1:0]  b_q;
    logic [SIZE-1:0]  acc_q;
    logic [SIZE-1:0]  base_q;
    logic [SIZE-1:0]  e_q;
    logic [CNT_W-1:0] bit_cnt_q;
    logic             busy_q;
    logic             start_q;
    logic [SIZE-1:0]  m_tdata_q;
    logic             m_tvalid_q;

    logic             accept_c;
    logic [SIZE-1:0]  e_c;
    logic [SIZE-1:0]  mm_x_c;
    logic [SIZE-1:0]  mm_y_c;
    logic [SIZE-1:0]  mm_result;
    logic             mm_done;

    // Sub-phase that handles exponent bit value bit_v.
    function automatic dec_state_e bit_state(input logic bit_v);
        return (CONST_TIME || bit_v) ? ST_EXP_MUL : ST_EXP_SQR;
    endfunction

    // Input acceptance, exponent derivation and multiplier operand routing.
    always_comb begin
        accept_c = 1'b0;
        if (state_q == ST_IDLE && !rst) begin
            accept_c = bus.input_p_tvalid && bus.input_x_key_tvalid &&
                       bus.input_a_tvalid && bus.input_b_tvalid;
        end
        e_c    = bus.input_p_tdata - SIZE'(1) - bus.input_x_key_tdata;
        mm_x_c = (state_q == ST_EXP_SQR) ? base_q : acc_q;
        mm_y_c = (state_q == ST_FINAL) ? b_q : base_q;
    end

    mod_mult #(
        .SIZE (SIZE)
    ) u_mod_mult (
        .clk    (clk),
        .rst    (rst),
        .start  (start_q),
        .x      (mm_x_c),
        .y      (mm_y_c),
        .p      (p_q),
        .result (mm_result),
        .done   (mm_done)
    );

    // Sequencer: latch operands, walk e LSB-first, fold in b, then hold m until taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            p_q        <= '0;
            b_q        <= '0;
            acc_q      <= '0;
            base_q     <= '0;
            e_q        <= '0;
            bit_cnt_q  <= '0;
            busy_q     <= 1'b0;
            start_q    <= 1'b0;
            m_tdata_q  <= '0;
            m_tvalid_q <= 1'b0;
        end else begin
            start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept_c) begin
                        p_q       <= bus.input_p_tdata;
                        b_q       <= bus.input_b_tdata;
                        base_q    <= bus.input_a_tdata;
                        acc_q     <= SIZE'(1);
                        e_q       <= e_c;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b0;
                        state_q   <= bit_state(e_c[0]);
                    end
                end
                ST_EXP_MUL, ST_EXP_SQR, ST_FINAL: begin
                    if (!busy_q) begin
                        // First op after accept; later ops chain directly off done.
                        start_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (mm_done) begin
                        start_q <= 1'b1;
                        case (state_q)
                            ST_EXP_MUL: begin
                                if (e_q[0]) acc_q <= mm_result;
                                state_q <= ST_EXP_SQR;
                            end
                            ST_EXP_SQR: begin
                                base_q <= mm_result;
                                e_q    <= e_q >> 1;
                                if (bit_cnt_q == CNT_W'(SIZE - 1)) begin
                                    state_q <= ST_FINAL;
                                end else begin
                                    bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                                    state_q   <= bit_state(e_q[1]);
                                end
                            end
                            default: begin
                                acc_q   <= mm_result;
                                start_q <= 1'b0;
                                busy_q  <= 1'b0;
                                state_q <= ST_OUT;
                            end
                        endcase
                    end
                end
                ST_OUT: begin
                    if (!m_tvalid_q) begin
                        m_tvalid_q <= 1'b1;
                        m_tdata_q  <= acc_q;
                    end else if (bus.output_m_tready) begin
                        m_tvalid_q <= 1'b0;
                        state_q    <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.input_a_tready  = accept_c;
    assign bus.input_b_tready  = accept_c;
    assign bus.output_m_tdata  = m_tdata_q;
    assign bus.output_m_tvalid = m_tvalid_q;

endmodule
